// File: rtl/dm_stage.sv
`default_nettype none
// ============================================================================
//  Module      : dm_stage
//  Description : MIPS M-stage data memory. Word-organised on-chip RAM with
//                word/half/byte stores, sign/zero-extended combinational
//                loads, and combinational misalign/range/size error flag.
//                The active-low reset clears the whole RAM asynchronously.
//  Revision    : 1.0 - initial release
// ============================================================================
module dm_stage #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter logic [31:0] BASE       = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_we,
  input  logic        mem_re,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  output logic [31:0] rdata,
  output logic        addr_err
);

  localparam int unsigned c_DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [1:0]  c_SIZE_WORD = 2'b00;
  localparam logic [1:0]  c_SIZE_HALF = 2'b01;
  localparam logic [1:0]  c_SIZE_BYTE = 2'b10;

  // Storage: packed so the asynchronous clear is a single assignment.
  logic [c_DEPTH-1:0][31:0] mem_q;

  logic [32:0]           w_offset;
  logic                  w_below_base;
  logic                  w_above_top;
  logic                  w_misaligned;
  logic                  w_bad_size;
  logic                  w_req;
  logic                  w_err;
  logic                  w_store;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [1:0]            w_lane;
  logic [31:0]           w_old_word;
  logic [15:0]           w_half;
  logic [7:0]            w_byte;
  logic [31:0]           w_load_data;
  logic [31:0]           word_d;
  logic                  unused_offset_lsbs;

  // Offset from BASE computed one bit wider so a borrow marks addr < BASE.
  assign w_offset     = {1'b0, addr} - {1'b0, BASE};
  assign w_below_base = w_offset[32];
  // Any set bit above the word index means the access lies past the top word;
  // no aliasing back into the array.
  assign w_above_top  = |w_offset[31:ADDR_WIDTH+2];
  assign w_idx        = w_offset[ADDR_WIDTH+1:2];
  // BASE is 4-aligned, so the byte lane comes straight from the address.
  assign w_lane       = addr[1:0];
  assign unused_offset_lsbs = ^w_offset[1:0];

  assign w_bad_size = (mem_size == 2'b11);
  assign w_req      = mem_we | mem_re;

  // Alignment rule per access size: word on 4, half on 2, byte anywhere.
  always_comb begin
    w_misaligned = 1'b0;
    case (mem_size)
      c_SIZE_WORD: w_misaligned = (w_lane != 2'b00);
      c_SIZE_HALF: w_misaligned = w_lane[0];
      default:     w_misaligned = 1'b0;
    endcase
  end

  assign w_err    = w_req & (w_below_base | w_above_top | w_misaligned | w_bad_size);
  assign addr_err = w_err;
  assign w_store  = mem_we & ~w_err;

  // Current contents of the addressed word; feeds both the load path and the
  // read-modify-write merge for partial stores (so a same-cycle load sees
  // the pre-store value).
  assign w_old_word = mem_q[w_idx];
  assign w_half     = w_lane[1] ? w_old_word[31:16] : w_old_word[15:0];
  assign w_byte     = w_old_word[{w_lane, 3'b000} +: 8];

  // Load data selection and sign/zero extension; zero when idle or in error.
  always_comb begin
    w_load_data = 32'h0000_0000;
    if (mem_re && !w_err) begin
      case (mem_size)
        c_SIZE_WORD: w_load_data = w_old_word;
        c_SIZE_HALF: w_load_data = {{16{~load_unsigned & w_half[15]}}, w_half};
        c_SIZE_BYTE: w_load_data = {{24{~load_unsigned & w_byte[7]}}, w_byte};
        default:     w_load_data = 32'h0000_0000;
      endcase
    end
  end

  assign rdata = w_load_data;

  // Merge store data into the old word at the selected lane(s).
  always_comb begin
    word_d = w_old_word;
    case (mem_size)
      c_SIZE_WORD: word_d = wdata;
      c_SIZE_HALF: word_d[{w_lane[1], 4'b0000} +: 16] = wdata[15:0];
      c_SIZE_BYTE: word_d[{w_lane, 3'b000} +: 8]      = wdata[7:0];
      default:     word_d = w_old_word;
    endcase
  end

  // RAM update: asynchronous full clear on reset, otherwise commit a legal
  // store on the rising edge. Reset low at an edge discards the store.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q <= '0;
    end else if (w_store) begin
      mem_q[w_idx] <= word_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dm_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dm_stage
//  Description : Self-checking bench for dm_stage: directed vector table,
//                reset-mid-store sequence, and random traffic against a
//                byte-addressed reference memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dm_stage;

  localparam int          AW        = 10;
  localparam logic [31:0] BASE      = 32'h0000_0000;
  localparam int          MEM_BYTES = 4 << AW;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        mem_we = 1'b0;
  logic        mem_re = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic        load_unsigned = 1'b0;
  logic [31:0] rdata;
  logic        addr_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference memory as individual bytes (little-endian).
  logic [7:0] mb [MEM_BYTES];

  dm_stage #(.ADDR_WIDTH(AW), .BASE(BASE)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .wdata        (wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_size     (mem_size),
    .load_unsigned(load_unsigned),
    .rdata        (rdata),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void m_clear();
    for (int i = 0; i < MEM_BYTES; i++) mb[i] = 8'h00;
  endfunction

  function automatic bit m_err(input logic we, input logic re, input logic [1:0] sz,
                               input logic [31:0] a);
    longint unsigned la;
    la = longint'(a);
    if (!(we || re)) return 1'b0;
    if (sz == 2'b11) return 1'b1;
    if (la < longint'(BASE)) return 1'b1;
    if (la - longint'(BASE) >= longint'(MEM_BYTES)) return 1'b1;
    if (sz == 2'b00 && (a % 4) != 0) return 1'b1;
    if (sz == 2'b01 && (a % 2) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic re, input logic err, input logic [1:0] sz,
                                         input logic uns, input logic [31:0] a);
    int unsigned off;
    logic [31:0] v;
    if (!re || err) return 32'h0;
    off = a - BASE;
    if (sz == 2'b00) return {mb[off+3], mb[off+2], mb[off+1], mb[off]};
    if (sz == 2'b01) begin
      v = {16'h0, mb[off+1], mb[off]};
      if (!uns && v >= 32'h8000) v = v | 32'hFFFF_0000;
      return v;
    end
    v = {24'h0, mb[off]};
    if (!uns && v >= 32'h80) v = v | 32'hFFFF_FF00;
    return v;
  endfunction

  function automatic void m_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    int unsigned off;
    int n;
    off = a - BASE;
    n = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 2 : 1;
    for (int i = 0; i < n; i++) mb[off+i] = 8'(wd >> (8 * i));
  endfunction

  // One pipeline cycle: drive after the falling edge, sample mid-low-phase,
  // and let the reference commit what the DUT will commit at the next rise.
  task automatic cycle(input logic we, input logic re, input logic [1:0] sz, input logic uns,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic er,
                       output logic [31:0] m_rd, output logic m_er);
    @(negedge clk);
    mem_we = we; mem_re = re; mem_size = sz; load_unsigned = uns; addr = a; wdata = wd;
    #2;
    rd = rdata;
    er = addr_err;
    m_er = m_err(we, re, sz, a);
    m_rd = m_load(re, m_er, sz, uns, a);
    if (we && !m_er) m_store(sz, a, wd);
  endtask

  typedef struct {
    string       name;
    logic        we;
    logic        re;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic we, input logic re,
                              input logic [1:0] sz, input logic uns, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] exp_rd,
                              input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.re = re; v.sz = sz; v.uns = uns;
    v.a = a; v.wd = wd; v.exp_rd = exp_rd; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  initial begin
    logic [31:0] rd, m_rd;
    logic        er, m_er;
    int          r;
    logic [31:0] ra;

    m_clear();
    // Reset pulse in the middle of the first cycle.
    #3 reset = 1'b0;
    #4 reset = 1'b1;

    //   name            we re sz     uns addr           wdata          rdata          err
    add("lw_after_rst",   0, 1, 2'b00, 0, 32'h0000_0010, 32'h0,         32'h0000_0000, 0);
    add("sw_same_lw",     1, 1, 2'b00, 0, 32'h0000_0020, 32'h8765_4321, 32'h0000_0000, 0);
    add("lw_after_sw",    0, 1, 2'b00, 0, 32'h0000_0020, 32'h0,         32'h8765_4321, 0);
    add("sh_beef",        1, 0, 2'b01, 0, 32'h0000_0022, 32'h0000_BEEF, 32'h0000_0000, 0);
    add("lw_after_sh",    0, 1, 2'b00, 0, 32'h0000_0020, 32'h0,         32'hBEEF_4321, 0);
    add("sb_80",          1, 0, 2'b10, 0, 32'h0000_0021, 32'hFFFF_FF80, 32'h0000_0000, 0);
    add("lw_after_sb",    0, 1, 2'b00, 0, 32'h0000_0020, 32'h0,         32'hBEEF_8021, 0);
    add("lb_21",          0, 1, 2'b10, 0, 32'h0000_0021, 32'h0,         32'hFFFF_FF80, 0);
    add("lbu_21",         0, 1, 2'b10, 1, 32'h0000_0021, 32'h0,         32'h0000_0080, 0);
    add("lh_22",          0, 1, 2'b01, 0, 32'h0000_0022, 32'h0,         32'hFFFF_BEEF, 0);
    add("lhu_22",         0, 1, 2'b01, 1, 32'h0000_0022, 32'h0,         32'h0000_BEEF, 0);
    add("sw_misalign",    1, 0, 2'b00, 0, 32'h0000_0022, 32'h1111_1111, 32'h0000_0000, 1);
    add("sh_misalign",    1, 0, 2'b01, 0, 32'h0000_0023, 32'h0000_2222, 32'h0000_0000, 1);
    add("lw_unchanged",   0, 1, 2'b00, 0, 32'h0000_0020, 32'h0,         32'hBEEF_8021, 0);
    add("lw_misalign",    0, 1, 2'b00, 0, 32'h0000_0021, 32'h0,         32'h0000_0000, 1);
    add("sw_top",         1, 0, 2'b00, 0, 32'h0000_0FFC, 32'h1234_5678, 32'h0000_0000, 0);
    add("lw_top",         0, 1, 2'b00, 0, 32'h0000_0FFC, 32'h0,         32'h1234_5678, 0);
    add("lb_top_byte",    0, 1, 2'b10, 0, 32'h0000_0FFF, 32'h0,         32'h0000_0012, 0);
    add("sw_oor",         1, 0, 2'b00, 0, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000, 1);
    add("lw_word0",       0, 1, 2'b00, 0, 32'h0000_0000, 32'h0,         32'h0000_0000, 0);
    add("lw_oor",         0, 1, 2'b00, 0, 32'h0000_1000, 32'h0,         32'h0000_0000, 1);
    add("size11",         0, 1, 2'b11, 0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1);
    add("bubble",         0, 0, 2'b11, 0, 32'h0000_1003, 32'hFFFF_FFFF, 32'h0000_0000, 0);
    add("lw_high_addr",   0, 1, 2'b00, 0, 32'hFFFF_FFFC, 32'h0,         32'h0000_0000, 1);

    foreach (vecs[i]) begin
      cycle(vecs[i].we, vecs[i].re, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd,
            rd, er, m_rd, m_er);
      check({vecs[i].name, ".rdata"}, rd, vecs[i].exp_rd);
      check({vecs[i].name, ".err"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
    end

    // Reset mid-operation: fill 0x00..0x3C, then assert reset during sw @0x40.
    for (int i = 0; i < 16; i++)
      cycle(1, 0, 2'b00, 0, 32'(i * 4), 32'hA500_0000 | 32'(i + 1), rd, er, m_rd, m_er);
    cycle(0, 1, 2'b00, 0, 32'h3C, 32'h0, rd, er, m_rd, m_er);
    check("fill_readback", rd, 32'hA500_0010);
    @(negedge clk);
    mem_we = 1'b1; mem_re = 1'b0; mem_size = 2'b00; addr = 32'h40; wdata = 32'h00C0_FFEE;
    #2 reset = 1'b0;
    m_clear();
    @(negedge clk);
    mem_we = 1'b0; mem_re = 1'b1; addr = 32'h3C;
    #2;
    check("load_under_reset", rdata, 32'h0);
    check("err_under_reset", {31'b0, addr_err}, 32'h0);
    #1 reset = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      cycle(0, 1, 2'b00, 0, 32'(i * 4), 32'h0, rd, er, m_rd, m_er);
      check($sformatf("cleared_%0h", i * 4), rd, 32'h0);
    end
    // First edge after release must honour a store.
    cycle(1, 0, 2'b00, 0, 32'h40, 32'h5A5A_A5A5, rd, er, m_rd, m_er);
    cycle(0, 1, 2'b00, 0, 32'h40, 32'h0, rd, er, m_rd, m_er);
    check("store_after_release", rd, 32'h5A5A_A5A5);

    // Random traffic against the byte-level reference.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r < 7)      ra = 32'($urandom_range(0, 127));
      else if (r < 9) ra = 32'h0FF0 + 32'($urandom_range(0, 31));
      else            ra = $urandom;
      cycle(1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom), ra, $urandom,
            rd, er, m_rd, m_er);
      check($sformatf("rand%0d.rdata@%h", n, ra), rd, m_rd);
      check($sformatf("rand%0d.err@%h", n, ra), {31'b0, er}, {31'b0, m_er});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
